// File: rtl/pool_stream_engine_pkg.sv
// rtl/pool_stream_engine_pkg.sv - shared types and width helpers for the pooling engine
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_state_e;

  // Right shift that turns a POOL*POOL window sum into its floor average.
  function automatic int pool_shift(input int pool);
    return 2 * $clog2(pool);
  endfunction

  function automatic int pool_acc_w(input int data_w, input int pool);
    return data_w + pool_shift(pool);
  endfunction

  function automatic bit pool_legal(input int pool);
    return (pool == 2) || (pool == 4) || (pool == 8);
  endfunction

endpackage

// File: rtl/pool_stream_engine_if.sv
// rtl/pool_stream_engine_if.sv - pixel-in / pooled-pixel-out stream pair
interface pool_stream_engine_if #(
  parameter int DATA_W = 16
);

  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/pool_stream_engine_combine.sv
// rtl/pool_stream_engine_combine.sv - per-pixel window combine and final pooled value
module pool_combine
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int POOL   = 2,
  localparam int ACC_W = pool_acc_w(DATA_W, POOL)
) (
  input  logic                     first_i,
  input  pool_mode_e               mode_i,
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [DATA_W-1:0] pix_i,
  output logic signed [ACC_W-1:0]  acc_o,
  output logic signed [DATA_W-1:0] res_o
);

  localparam int SHIFT = pool_shift(POOL);

  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;

  assign pix_ext = {{SHIFT{pix_i[DATA_W-1]}}, pix_i};
  assign sum     = acc_i + pix_ext;

  always_comb begin
    acc_o = sum;
    if (first_i) begin
      acc_o = pix_ext;
    end else if (mode_i == POOL_MAX) begin
      acc_o = (pix_ext > acc_i) ? pix_ext : acc_i;
    end
  end

  // Arithmetic shift floors toward minus infinity; the quotient always fits DATA_W.
  assign shifted = acc_o >>> SHIFT;
  assign res_o   = (mode_i == POOL_MAX) ? acc_o[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/pool_stream_engine.sv
// rtl/pool_stream_engine.sv - streaming POOLxPOOL average/max pooling engine
module pool_stream_engine
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  pool_stream_engine_if.slave  strm,
  output logic                 busy,
  output logic                 finish
);

  localparam int LOG_P  = $clog2(POOL);
  localparam int ACC_W  = pool_acc_w(DATA_W, POOL);
  localparam int NOC    = IMG_W / POOL;
  localparam int NOR    = IMG_H / POOL;
  localparam int USED_W = NOC * POOL;
  localparam int USED_H = NOR * POOL;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int OCW    = (NOC > 1) ? $clog2(NOC) : 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_DONE  = DONE;

  if (!pool_legal(POOL)) begin : g_pool_check
    $error("pool_stream_engine: POOL must be 2, 4 or 8");
  end

  logic [1:0]               state_q, state_d;
  pool_mode_e               mode_q;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [ACC_W-1:0]  acc_q [NOC];
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_valid_q;

  logic                     in_ready;
  logic                     pix_fire;
  logic                     in_win;
  logic                     win_first;
  logic                     win_close;
  logic                     last_col;
  logic                     last_row;
  logic [OCW-1:0]           oc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [DATA_W-1:0] res;

  // A held result blocks input, so a closing pixel can never overwrite it.
  assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || strm.out_ready);
  assign pix_fire  = strm.in_valid && in_ready;

  assign in_win    = (int'(col_q) < USED_W) && (int'(row_q) < USED_H);
  assign win_first = (col_q[LOG_P-1:0] == '0) && (row_q[LOG_P-1:0] == '0);
  assign win_close = (&col_q[LOG_P-1:0]) && (&row_q[LOG_P-1:0]);
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign last_row  = (row_q == RW'(IMG_H - 1));
  assign oc        = in_win ? OCW'(col_q >> LOG_P) : '0;

  pool_combine #(
    .DATA_W (DATA_W),
    .POOL   (POOL)
  ) u_combine (
    .first_i (win_first),
    .mode_i  (mode_q),
    .acc_i   (acc_q[oc]),
    .pix_i   (strm.in_data),
    .acc_o   (acc_nxt),
    .res_o   (res)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_RUN: begin
        if (pix_fire) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= POOL_AVG;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (state_q == ST_IDLE && start) begin
        mode_q <= pool_mode_e'(mode);
      end
    end
  end

  // Window partials need no reset: each window's first pixel overwrites its entry.
  always_ff @(posedge clk) begin
    if (pix_fire && in_win) begin
      acc_q[oc] <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (pix_fire && in_win && win_close) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res;
    end else if (out_valid_q && strm.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_data  = out_data_q;
  assign strm.out_valid = out_valid_q;
  assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign finish         = (state_q == ST_DONE);

endmodule

// File: tb/tb_pool_stream_engine.sv
// tb/tb_pool_stream_engine.sv - directed bench for 4x4 and 5x5 pooling engines
module tb_pool_stream_engine;

  logic clk = 1'b0;
  logic rst_n;
  logic a_start, a_mode, a_busy, a_finish;
  logic b_start, b_mode, b_busy, b_finish;

  int total = 0;
  int bad   = 0;
  int a_q[$];
  int b_q[$];
  int a_fin = 0;
  int b_fin = 0;
  int a_stall = 0;
  int ramp[25];
  int negf[16];

  pool_stream_engine_if #(.DATA_W(16)) a_if ();
  pool_stream_engine_if #(.DATA_W(16)) b_if ();

  pool_stream_engine #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .POOL(2)) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (a_start),
    .mode   (a_mode),
    .strm   (a_if),
    .busy   (a_busy),
    .finish (a_finish)
  );

  pool_stream_engine #(.DATA_W(16), .IMG_W(5), .IMG_H(5), .POOL(2)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (b_start),
    .mode   (b_mode),
    .strm   (b_if),
    .busy   (b_busy),
    .finish (b_finish)
  );

  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so the falling edge sees what the next edge commits.
  always @(negedge clk) begin
    if (a_if.out_valid && a_if.out_ready) a_q.push_back(int'(a_if.out_data));
    if (b_if.out_valid && b_if.out_ready) b_q.push_back(int'(b_if.out_data));
    if (a_finish) a_fin++;
    if (b_finish) b_fin++;
    if (a_if.in_valid && !a_if.in_ready && a_busy) a_stall++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input int q[$], input int e0, input int e1,
                         input int e2, input int e3);
    int exp[4];
    exp = '{e0, e1, e2, e3};
    check({tag, " count"}, q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s out%0d", tag, i), (i < q.size()) ? q[i] : -99999, exp[i]);
    end
  endtask

  task automatic clear_mon();
    a_q.delete();
    b_q.delete();
    a_fin   = 0;
    b_fin   = 0;
    a_stall = 0;
  endtask

  task automatic start_a(input logic m);
    a_mode  = m;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic m);
    b_mode  = m;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic push_a(input int px);
    int g = 0;
    a_if.in_data  = 16'(px);
    a_if.in_valid = 1'b1;
    @(negedge clk);
    while (!a_if.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("a push ready", int'(a_if.in_ready), 1);
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
  endtask

  task automatic push_b(input int px);
    int g = 0;
    b_if.in_data  = 16'(px);
    b_if.in_valid = 1'b1;
    @(negedge clk);
    while (!b_if.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("b push ready", int'(b_if.in_ready), 1);
    @(posedge clk); #1;
    b_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    int g = 0;
    @(negedge clk);
    while (a_busy && g < 300) begin
      @(negedge clk);
      g++;
    end
    check({tag, " idle"}, int'(a_busy), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle_b(input string tag);
    int g = 0;
    @(negedge clk);
    while (b_busy && g < 300) begin
      @(negedge clk);
      g++;
    end
    check({tag, " idle"}, int'(b_busy), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    a_start        = 1'b0;
    a_mode         = 1'b0;
    b_start        = 1'b0;
    b_mode         = 1'b0;
    a_if.in_data   = '0;
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    b_if.in_data   = '0;
    b_if.in_valid  = 1'b0;
    b_if.out_ready = 1'b1;
    for (int i = 0; i < 25; i++) ramp[i] = i;
    for (int i = 0; i < 16; i++) negf[i] = 0;
    negf[0] = -1;    negf[1] = -2;    negf[4] = -3;    negf[5] = -4;
    negf[2] = 32767; negf[3] = 32767; negf[6] = 32767; negf[7] = 32767;

    repeat (3) @(posedge clk); #1;
    check("rst busy", int'(a_busy), 0);
    check("rst finish", int'(a_finish), 0);
    check("rst out_valid", int'(a_if.out_valid), 0);
    check("rst out_data", int'(a_if.out_data), 0);
    check("rst in_ready", int'(a_if.in_ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle in_ready", int'(a_if.in_ready), 0);

    clear_mon();
    start_a(1'b0);
    check("t1 busy after start", int'(a_busy), 1);
    for (int i = 0; i < 16; i++) push_a(ramp[i]);
    wait_idle_a("t1");
    check_q("t1 avg", a_q, 2, 4, 10, 12);
    check("t1 finish", a_fin, 1);

    clear_mon();
    start_a(1'b1);
    for (int i = 0; i < 16; i++) push_a(ramp[i]);
    wait_idle_a("t2");
    check_q("t2 max", a_q, 5, 7, 13, 15);
    check("t2 finish", a_fin, 1);

    clear_mon();
    start_a(1'b0);
    for (int i = 0; i < 16; i++) push_a(negf[i]);
    wait_idle_a("t3");
    check_q("t3 neg avg", a_q, -3, 32767, 0, 0);

    clear_mon();
    start_a(1'b1);
    for (int i = 0; i < 16; i++) push_a(negf[i]);
    wait_idle_a("t3m");
    check_q("t3 neg max", a_q, -1, 32767, 0, 0);

    clear_mon();
    fork
      begin
        start_a(1'b0);
        for (int i = 0; i < 16; i++) push_a(ramp[i]);
        wait_idle_a("t4");
      end
      begin
        int g = 0;
        while (a_q.size() < 1 && g < 100) begin
          @(negedge clk);
          g++;
        end
        check("t4 first seen", int'(a_q.size() >= 1), 1);
        @(posedge clk); #1;
        a_if.out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        a_if.out_ready = 1'b1;
      end
    join
    check_q("t4 backpressure", a_q, 2, 4, 10, 12);
    check("t4 stalled", int'(a_stall > 0), 1);
    check("t4 finish", a_fin, 1);

    clear_mon();
    start_b(1'b0);
    for (int i = 0; i < 25; i++) push_b(ramp[i]);
    wait_idle_b("t5");
    check_q("t5 5x5", b_q, 3, 5, 13, 15);
    check("t5 finish", b_fin, 1);

    start_a(1'b0);
    for (int i = 0; i < 6; i++) push_a(ramp[i]);
    rst_n = 1'b0;
    #2;
    check("t6 rst busy", int'(a_busy), 0);
    check("t6 rst out_valid", int'(a_if.out_valid), 0);
    check("t6 rst in_ready", int'(a_if.in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    start_a(1'b0);
    for (int i = 0; i < 5; i++) push_a(ramp[i]);
    a_mode  = 1'b1;
    a_start = 1'b1;
    push_a(ramp[5]);
    a_start = 1'b0;
    a_mode  = 1'b0;
    for (int i = 6; i < 16; i++) push_a(ramp[i]);
    wait_idle_a("t6");
    check_q("t6 after abort", a_q, 2, 4, 10, 12);
    check("t6 finish", a_fin, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
